// File: rtl/synapse_accumulator_pkg.sv
// Shared types and default sizes for the synaptic weighting stage.
package synapse_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int N_IN_DEF     = 16;
    localparam int N_OUT_DEF    = 4;
    localparam int WEIGHT_W_DEF = 8;
    localparam int SUM_W_DEF    = 16;

    // Width of a flat weight index i*n_out + j; never narrower than one bit.
    function automatic int addr_w(input int n_in, input int n_out);
        return (n_in * n_out > 1) ? $clog2(n_in * n_out) : 1;
    endfunction

endpackage

// File: rtl/synapse_accumulator_if.sv
// Bundle of the encode-step request, weight write port and result outputs.
//
// Handshake: tick is a request with no ready; it is accepted only while busy
// is low, otherwise it is dropped and overrun latches. out_valid is a
// one-cycle pulse with no backpressure; out_value is updated in that same
// cycle and holds until the next pulse.
interface synapse_accumulator_if #(
    parameter int N_IN     = synapse_accumulator_pkg::N_IN_DEF,
    parameter int N_OUT    = synapse_accumulator_pkg::N_OUT_DEF,
    parameter int WEIGHT_W = synapse_accumulator_pkg::WEIGHT_W_DEF,
    parameter int SUM_W    = synapse_accumulator_pkg::SUM_W_DEF,
    parameter int ADDR_W   = synapse_accumulator_pkg::addr_w(N_IN, N_OUT)
);
    import synapse_accumulator_pkg::*;

    logic                   tick;
    logic [N_IN-1:0]        spike_in;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [WEIGHT_W-1:0]    wr_data;
    logic [N_OUT*SUM_W-1:0] out_value;
    logic                   out_valid;
    logic                   busy;
    logic                   overrun;
    state_t                 state;

    modport master (
        output tick, spike_in, wr_en, wr_addr, wr_data,
        input  out_value, out_valid, busy, overrun, state
    );

    modport slave (
        input  tick, spike_in, wr_en, wr_addr, wr_data,
        output out_value, out_valid, busy, overrun, state
    );

endinterface

// File: rtl/synapse_accumulator_sat_add.sv
// Signed accumulator plus sign-extended weight, clamped to the accumulator range.
module sat_add #(
    parameter int A_W = 16,
    parameter int B_W = 8
) (
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [A_W-1:0] y
);

    logic signed [A_W:0] sum;

    // One guard bit makes overflow visible as a disagreement of the top two bits.
    always_comb begin
        sum = {a[A_W-1], a} + {{(A_W + 1 - B_W){b[B_W-1]}}, b};
        y   = sum[A_W-1:0];
        if (sum[A_W] != sum[A_W-1]) begin
            y = sum[A_W] ? {1'b1, {(A_W-1){1'b0}}} : {1'b0, {(A_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/synapse_accumulator.sv
// Scans latched presynaptic spikes one per cycle and accumulates the weights
// of active synapses into N_OUT saturating sums, then emits them with a pulse.
module synapse_accumulator
    import synapse_accumulator_pkg::*;
#(
    parameter int N_IN     = N_IN_DEF,
    parameter int N_OUT    = N_OUT_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int SUM_W    = SUM_W_DEF
) (
    input logic clk,
    input logic rst,
    synapse_accumulator_if.slave bus
);

    localparam int ADDR_W = addr_w(N_IN, N_OUT);
    localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int N_W    = N_IN * N_OUT;

    state_t                      state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [N_IN-1:0]             spk_q;
    logic signed [WEIGHT_W-1:0]  w_q     [N_W];
    logic signed [SUM_W-1:0]     acc_q   [N_OUT];
    logic signed [SUM_W-1:0]     acc_nxt [N_OUT];
    logic [N_OUT*SUM_W-1:0]      out_value_q;
    logic                        out_valid_q;
    logic                        busy_q;
    logic                        overrun_q;
    logic [ADDR_W-1:0]           row_base;
    logic                        wr_ok;

    assign row_base = ADDR_W'(idx_q) * ADDR_W'(N_OUT);
    assign wr_ok    = bus.wr_en && (int'({1'b0, bus.wr_addr}) < N_W);

    // Weight array: writes land at the next edge, so a same-cycle read sees the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_W; i++) begin
                w_q[i] <= '0;
            end
        end else if (wr_ok) begin
            w_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        sat_add #(
            .A_W (SUM_W),
            .B_W (WEIGHT_W)
        ) u_sat_add (
            .a (acc_q[j]),
            .b (w_q[row_base + ADDR_W'(j)]),
            .y (acc_nxt[j])
        );
    end

    // Scan controller: IDLE latches spikes on tick, ACCUM walks one input per cycle, DONE publishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            spk_q       <= '0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            if (bus.tick && state_q != IDLE) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.tick) begin
                        spk_q   <= bus.spike_in;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ACCUM;
                        for (int j = 0; j < N_OUT; j++) begin
                            acc_q[j] <= '0;
                        end
                    end
                end
                ACCUM: begin
                    if (spk_q[idx_q]) begin
                        for (int j = 0; j < N_OUT; j++) begin
                            acc_q[j] <= acc_nxt[j];
                        end
                    end
                    if (idx_q == IDX_W'(N_IN - 1)) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        out_value_q[j*SUM_W +: SUM_W] <= acc_q[j];
                    end
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_value = out_value_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Directed bench: default-width instance plus a SUM_W=10 instance sharing its inputs.
module tb_synapse_accumulator;
    import synapse_accumulator_pkg::*;

    localparam int N_IN     = 16;
    localparam int N_OUT    = 4;
    localparam int WEIGHT_W = 8;
    localparam int SUM_W    = 16;
    localparam int SUM_W_B  = 10;
    localparam int ADDR_W   = addr_w(N_IN, N_OUT);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    synapse_accumulator_if #(.N_IN(N_IN), .N_OUT(N_OUT), .WEIGHT_W(WEIGHT_W), .SUM_W(SUM_W))   bus_a ();
    synapse_accumulator_if #(.N_IN(N_IN), .N_OUT(N_OUT), .WEIGHT_W(WEIGHT_W), .SUM_W(SUM_W_B)) bus_b ();

    assign bus_b.tick     = bus_a.tick;
    assign bus_b.spike_in = bus_a.spike_in;
    assign bus_b.wr_en    = bus_a.wr_en;
    assign bus_b.wr_addr  = bus_a.wr_addr;
    assign bus_b.wr_data  = bus_a.wr_data;

    synapse_accumulator #(.N_IN(N_IN), .N_OUT(N_OUT), .WEIGHT_W(WEIGHT_W), .SUM_W(SUM_W)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    synapse_accumulator #(.N_IN(N_IN), .N_OUT(N_OUT), .WEIGHT_W(WEIGHT_W), .SUM_W(SUM_W_B)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic signed [31:0] slice_a(input int j);
        logic signed [SUM_W-1:0] v;
        v = bus_a.out_value[j*SUM_W +: SUM_W];
        return 32'(v);
    endfunction

    function automatic logic signed [31:0] slice_b(input int j);
        logic signed [SUM_W_B-1:0] v;
        v = bus_b.out_value[j*SUM_W_B +: SUM_W_B];
        return 32'(v);
    endfunction

    task automatic check_slices_a(input string tag, input int e0, input int e1, input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int j = 0; j < N_OUT; j++) check_eq($sformatf("%s_a%0d", tag, j), slice_a(j), e[j]);
    endtask

    task automatic check_slices_b(input string tag, input int e);
        for (int j = 0; j < N_OUT; j++) check_eq($sformatf("%s_b%0d", tag, j), slice_b(j), e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int addr, input int data);
        bus_a.wr_en   = 1'b1;
        bus_a.wr_addr = ADDR_W'(addr);
        bus_a.wr_data = WEIGHT_W'(data);
        step();
        bus_a.wr_en   = 1'b0;
    endtask

    task automatic set_all(input int data);
        for (int i = 0; i < N_IN * N_OUT; i++) write_w(i, data);
    endtask

    task automatic pulse_tick(input logic [N_IN-1:0] spikes);
        bus_a.tick     = 1'b1;
        bus_a.spike_in = spikes;
        step();
        bus_a.tick     = 1'b0;
        bus_a.spike_in = '0;
    endtask

    task automatic wait_valid(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (!bus_a.out_valid && n < 60) begin
            nb += int'(bus_a.busy);
            step();
            n++;
        end
        if (!bus_a.out_valid) check_eq("valid_timeout", 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, nb, n_valid;
        rst            = 1'b1;
        bus_a.tick     = 1'b0;
        bus_a.spike_in = '0;
        bus_a.wr_en    = 1'b0;
        bus_a.wr_addr  = '0;
        bus_a.wr_data  = '0;
        repeat (3) step();
        rst = 1'b0;

        check_eq("rst_out_valid", 32'(bus_a.out_valid), 0);
        check_eq("rst_busy",      32'(bus_a.busy), 0);
        check_eq("rst_overrun",   32'(bus_a.overrun), 0);
        check_eq("rst_state",     32'(bus_a.state), 32'(IDLE));
        check_slices_a("rst_value", 0, 0, 0, 0);

        // All weights 16, all spikes: 16 * 16 = 256 on every output.
        set_all(16);
        pulse_tick(16'hFFFF);
        wait_valid(n, nb);
        check_eq("lat_full", n, 17);
        check_eq("busy_cycles", nb, 17);
        check_slices_a("w16", 256, 256, 256, 256);
        check_slices_b("w16", 256);
        step();
        check_eq("valid_pulse_len", 32'(bus_a.out_valid), 0);
        check_eq("value_hold", slice_a(2), 256);
        check_eq("busy_after", 32'(bus_a.busy), 0);

        // Saturation: 16 * 127 = 2032 fits 16 bits but clamps to 511 at 10 bits.
        set_all(127);
        pulse_tick(16'hFFFF);
        wait_valid(n, nb);
        check_slices_a("w127", 2032, 2032, 2032, 2032);
        check_slices_b("w127_sat", 511);
        set_all(-128);
        pulse_tick(16'hFFFF);
        wait_valid(n, nb);
        check_slices_a("wm128", -2048, -2048, -2048, -2048);
        check_slices_b("wm128_sat", -512);

        // Reset in the middle of a scan.
        set_all(16);
        pulse_tick(16'hFFFF);
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_busy",  32'(bus_a.busy), 0);
        check_eq("mid_rst_state", 32'(bus_a.state), 32'(IDLE));
        check_slices_a("mid_rst_value", 0, 0, 0, 0);
        n_valid = 0;
        for (int c = 0; c < 30; c++) begin
            n_valid += int'(bus_a.out_valid);
            step();
        end
        check_eq("mid_rst_no_valid", n_valid, 0);
        pulse_tick(16'hFFFF);
        wait_valid(n, nb);
        check_slices_a("mid_rst_weights", 0, 0, 0, 0);

        // Single active input with distinct per-output weights.
        for (int j = 0; j < N_OUT; j++) write_w(j, j + 1);
        pulse_tick(16'h0001);
        wait_valid(n, nb);
        check_slices_a("one_hot", 1, 2, 3, 4);
        check_eq("no_overrun_yet", 32'(bus_a.overrun), 0);

        // Tick while busy is dropped and flagged; tick right after out_valid is accepted.
        pulse_tick(16'h0001);
        repeat (4) step();
        pulse_tick(16'hFFFF);
        wait_valid(n, nb);
        check_eq("lat_with_overrun", n, 12);
        check_eq("overrun_set", 32'(bus_a.overrun), 1);
        check_slices_a("overrun_value", 1, 2, 3, 4);
        pulse_tick(16'h0000);
        wait_valid(n, nb);
        check_eq("lat_back_to_back", n, 17);
        check_slices_a("zero_spikes", 0, 0, 0, 0);
        check_eq("overrun_sticky", 32'(bus_a.overrun), 1);

        // Writes during a scan: row 0 already consumed, row 15 still pending.
        pulse_tick(16'h8001);
        step();
        for (int j = 0; j < N_OUT; j++) write_w(j, 50);
        for (int j = 0; j < N_OUT; j++) write_w(60 + j, j + 7);
        wait_valid(n, nb);
        check_eq("lat_wr_scan", n, 8);
        check_slices_a("wr_scan_mix", 8, 10, 12, 14);
        pulse_tick(16'h8001);
        wait_valid(n, nb);
        check_slices_a("wr_scan_new", 57, 58, 59, 60);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
